// File: rtl/window_pkg.sv
// Shared helpers for the K x K window line buffer: slot offsets, counter widths
// and kernel legality.
package window_pkg;

  localparam int unsigned WIN_COUNT_W    = 32;
  localparam int unsigned DEFAULT_KERNEL = 3;

  // Bit offset of window slot (r, c) inside the flattened window bus.
  function automatic int unsigned slot_offset(input int unsigned r, input int unsigned c,
                                              input int unsigned kernel,
                                              input int unsigned pixel_w);
    return pixel_w * (r * kernel + c);
  endfunction

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit kernel_legal(input int unsigned k);
    return (k >= 3) && (k <= 7) && (k % 2 == 1);
  endfunction

  localparam bit DEFAULT_KERNEL_LEGAL = kernel_legal(DEFAULT_KERNEL);

endpackage

// File: rtl/line_ram.sv
// One stored image line: synchronous write, combinational read.
module line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [window_pkg::cnt_width(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]                      wdata,
  input  logic [window_pkg::cnt_width(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]                      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/window_line_buffer.sv
// Raster pixel stream to K x K neighbourhood windows with valid/ready backpressure.
// Optional WIN_COUNT_EN adds o_win_count, a free-running count of consumed windows.
module window_line_buffer
  import window_pkg::*;
#(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned IMG_W   = 640,
  parameter int unsigned IMG_H   = 480,
  parameter int unsigned KERNEL  = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PIXEL_W-1:0]                 i_pixel,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [KERNEL*KERNEL*PIXEL_W-1:0]   o_window,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_eol,
  output logic                               o_eof,
  output logic                               o_frame_done
`ifdef WIN_COUNT_EN
  ,
  output logic [WIN_COUNT_W-1:0]             o_win_count
`endif
);

  localparam int unsigned LINES = KERNEL - 1;
  localparam int unsigned CW    = cnt_width(IMG_W);
  localparam int unsigned RW    = cnt_width(IMG_H);
  localparam int unsigned LPW   = cnt_width(LINES);
  localparam int unsigned WIN_W = KERNEL * KERNEL * PIXEL_W;

  if (!kernel_legal(KERNEL) || IMG_W < KERNEL || IMG_H < KERNEL) begin : g_bad_cfg
    $error("window_line_buffer: illegal KERNEL/IMG_W/IMG_H combination");
  end

  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [LPW-1:0]     wp;
  logic               accept;
  logic               col_last;
  logic               row_last;
  logic               interior;
  logic [PIXEL_W-1:0] ram_rd   [LINES];
  logic [PIXEL_W-1:0] col_data [KERNEL];
  logic [PIXEL_W-1:0] shift_q  [KERNEL][KERNEL];
  logic [PIXEL_W-1:0] shift_d  [KERNEL][KERNEL];
  logic [WIN_W-1:0]   win_d;

  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign interior = (col >= CW'(KERNEL - 1)) && (row >= RW'(KERNEL - 1));

  // Ring of line memories; the one at wp holds the oldest line and takes the new pixel.
  for (genvar i = 0; i < LINES; i++) begin : g_line
    line_ram #(
      .DEPTH(IMG_W),
      .WIDTH(PIXEL_W)
    ) u_line_ram (
      .clk  (clk),
      .we   (accept && (wp == LPW'(i))),
      .waddr(col),
      .wdata(i_pixel),
      .raddr(col),
      .rdata(ram_rd[i])
    );
  end

  // Column entering the window: oldest stored line on top, live pixel at the bottom.
  always_comb begin
    logic [LPW:0] sum;
    sum = '0;
    for (int r = 0; r < KERNEL; r++) col_data[r] = i_pixel;
    for (int r = 0; r < KERNEL - 1; r++) begin
      sum = {1'b0, wp} + (LPW + 1)'(r);
      if (sum >= (LPW + 1)'(LINES)) sum = sum - (LPW + 1)'(LINES);
      col_data[r] = ram_rd[sum[LPW-1:0]];
    end
  end

  always_comb begin
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) shift_d[r][c] = shift_q[r][c+1];
      shift_d[r][KERNEL-1] = col_data[r];
    end
  end

  always_comb begin
    win_d = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_d[slot_offset(r, c, KERNEL, PIXEL_W) +: PIXEL_W] = shift_d[r][c];
      end
    end
  end

  // Window shift registers keep updating across boundary pixels; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) shift_q <= shift_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      wp           <= '0;
      o_valid      <= 1'b0;
      o_eol        <= 1'b0;
      o_eof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_window     <= '0;
    end else begin
      o_frame_done <= accept && col_last && row_last;

      if (accept) begin
        if (col_last) begin
          col <= '0;
          wp  <= (wp == LPW'(LINES - 1)) ? '0 : wp + LPW'(1);
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if (accept && interior) begin
        o_valid  <= 1'b1;
        o_window <= win_d;
        o_eol    <= col_last;
        o_eof    <= col_last && row_last;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_eol   <= 1'b0;
        o_eof   <= 1'b0;
      end
    end
  end

`ifdef WIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) o_win_count <= '0;
    else if (o_valid && i_ready) o_win_count <= o_win_count + WIN_COUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// Randomised self-checking bench: reference windows are built from a stored image.
module tb_window_line_buffer;

  localparam int unsigned PW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 6;
  localparam int unsigned BW = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel3, pixel5;
  logic          ivalid3, ivalid5, iready3, iready5;
  logic          oready3, oready5, ovalid3, ovalid5;
  logic [71:0]   win3;
  logic [199:0]  win5;
  logic          eol3, eol5, eof3, eof5, fd3, fd5;
`ifdef WIN_COUNT_EN
  logic [31:0]   wc3, wc5;
`endif

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_win_q[$];
  bit            exp_eol_q[$];
  bit            exp_eof_q[$];
  logic [PW-1:0] pix_q[$];
  int            fr[H][W];

  always #5 clk = ~clk;

  window_line_buffer #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .KERNEL(3)) dut3 (
    .clk(clk), .reset(reset), .i_pixel(pixel3), .i_valid(ivalid3), .o_ready(oready3),
    .o_window(win3), .o_valid(ovalid3), .i_ready(iready3), .o_eol(eol3), .o_eof(eof3),
    .o_frame_done(fd3)
`ifdef WIN_COUNT_EN
    , .o_win_count(wc3)
`endif
  );

  window_line_buffer #(.PIXEL_W(PW), .IMG_W(W), .IMG_H(H), .KERNEL(5)) dut5 (
    .clk(clk), .reset(reset), .i_pixel(pixel5), .i_valid(ivalid5), .o_ready(oready5),
    .o_window(win5), .o_valid(ovalid5), .i_ready(iready5), .o_eol(eol5), .o_eof(eof5),
    .o_frame_done(fd5)
`ifdef WIN_COUNT_EN
    , .o_win_count(wc5)
`endif
  );

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: every interior (y, x) yields the K x K neighbourhood ending at (y, x).
  task automatic gen_frame(input int k, input int mode);
    logic [BW-1:0] w;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        fr[y][x] = (mode == 0) ? y * 8 + x : int'($urandom_range(0, 255));
        pix_q.push_back(PW'(fr[y][x]));
      end
    for (int y = k - 1; y < H; y++)
      for (int x = k - 1; x < W; x++) begin
        w = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            w[(r * k + c) * PW +: PW] = PW'(fr[y - k + 1 + r][x - k + 1 + c]);
        exp_win_q.push_back(w);
        exp_eol_q.push_back(x == W - 1);
        exp_eof_q.push_back((x == W - 1) && (y == H - 1));
      end
  endtask

  function automatic logic get_valid(input int k);
    return (k == 3) ? ovalid3 : ovalid5;
  endfunction
  function automatic logic get_oready(input int k);
    return (k == 3) ? oready3 : oready5;
  endfunction
  function automatic logic [BW-1:0] get_win(input int k);
    return (k == 3) ? BW'(win3) : win5;
  endfunction
  function automatic logic get_fd(input int k);
    return (k == 3) ? fd3 : fd5;
  endfunction

  task automatic drive(input int k, input logic v, input logic [PW-1:0] p, input logic rdy);
    ivalid3 = (k == 3) ? v : 1'b0;
    ivalid5 = (k == 5) ? v : 1'b0;
    pixel3  = p;
    pixel5  = p;
    iready3 = (k == 3) ? rdy : 1'b1;
    iready5 = (k == 5) ? rdy : 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ready_mode: 0 always, 1 toggling, 2 random. gap_at/abort_at < 0 disables them.
  task automatic run(input int k, input int ready_mode, input int gap_at, input int abort_at,
                     output int nwin, output int nfd, output logic [BW-1:0] first);
    int            sent = 0;
    int            gap  = 5;
    int            cyc  = 0;
    logic          held = 1'b0;
    logic [BW-1:0] held_win = '0;
    logic          v, rdy, iv;
    logic [BW-1:0] w;
    nwin  = 0;
    nfd   = 0;
    first = '0;
    while ((pix_q.size() > 0 || exp_win_q.size() > 0) && cyc < 2000 &&
           !(abort_at >= 0 && sent >= abort_at)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (get_fd(k)) nfd++;
      if (held) begin
        check("hold_valid", BW'(get_valid(k)), BW'(1));
        check("hold_window", get_win(k), held_win);
      end
      rdy = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      iv  = (pix_q.size() > 0);
      if (sent == gap_at && gap > 0) begin
        iv = 1'b0;
        gap--;
      end
      drive(k, iv, (pix_q.size() > 0) ? pix_q[0] : '0, rdy);
      #1;
      v = get_valid(k);
      w = get_win(k);
      if (v && !rdy) check("o_ready_low", BW'(get_oready(k)), BW'(0));
      if (v && rdy) begin
        if (exp_win_q.size() == 0) check("extra_window", BW'(1), BW'(0));
        else begin
          if (nwin == 0) first = w;
          check("window", w, exp_win_q.pop_front());
          check("eol", BW'((k == 3) ? eol3 : eol5), BW'(exp_eol_q.pop_front()));
          check("eof", BW'((k == 3) ? eof3 : eof5), BW'(exp_eof_q.pop_front()));
          nwin++;
        end
      end
      held     = v && !rdy;
      held_win = w;
      if (iv && get_oready(k)) begin
        void'(pix_q.pop_front());
        sent++;
      end
    end
    if (abort_at < 0) begin
      check("timeout_left", BW'(exp_win_q.size()), BW'(0));
      drive(k, 1'b0, '0, 1'b1);
      repeat (4) begin
        @(posedge clk);
        #1;
        if (get_fd(k)) nfd++;
        if (get_valid(k)) check("extra_window", BW'(1), BW'(0));
      end
    end
  endtask

  initial begin
    int            nwin, nfd;
    logic [BW-1:0] first, first_ref;
    logic [PW-1:0] slot;
    int            fw[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    first_ref = '0;
    for (int i = 0; i < 9; i++) first_ref[i * PW +: PW] = PW'(fw[i]);

    do_reset();
    check("rst_valid", BW'(ovalid3), BW'(0));
    check("rst_window", BW'(win3), BW'(0));
    check("rst_eol_eof", BW'({eol3, eof3}), BW'(0));
    check("rst_frame_done", BW'(fd3), BW'(0));
    check("rst_ready", BW'(oready3), BW'(1));

    gen_frame(3, 0);
    run(3, 0, -1, -1, nwin, nfd, first);
    check("t1_count", BW'(nwin), BW'(24));
    check("t1_first", first, first_ref);
    check("t1_frame_done", BW'(nfd), BW'(1));

    gen_frame(3, 0);
    run(3, 1, -1, -1, nwin, nfd, first);
    check("t2_count", BW'(nwin), BW'(24));
    check("t2_first", first, first_ref);

    gen_frame(3, 1);
    run(3, 0, 28, -1, nwin, nfd, first);
    check("t3_count", BW'(nwin), BW'(24));

    gen_frame(3, 0);
    gen_frame(3, 1);
    run(3, 2, -1, -1, nwin, nfd, first);
    check("t4_count", BW'(nwin), BW'(48));
    check("t4_frame_done", BW'(nfd), BW'(2));

    gen_frame(3, 1);
    run(3, 0, -1, 28, nwin, nfd, first);
    pix_q.delete();
    exp_win_q.delete();
    exp_eol_q.delete();
    exp_eof_q.delete();
    do_reset();
    check("t5_rst_valid", BW'(ovalid3), BW'(0));
    gen_frame(3, 0);
    run(3, 0, -1, -1, nwin, nfd, first);
    check("t5_count", BW'(nwin), BW'(24));
    check("t5_first", first, first_ref);
    check("t5_frame_done", BW'(nfd), BW'(1));

    gen_frame(5, 0);
    run(5, 2, -1, -1, nwin, nfd, first);
    check("k5_count", BW'(nwin), BW'(8));
    slot = first[24 * PW +: PW];
    check("k5_slot24", BW'(slot), BW'(36));
    check("k5_frame_done", BW'(nfd), BW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
